// File: rtl/guess_entry_if.sv
// guess_entry_if
//   Keyboard strobe bundle plus the downstream valid/ready word channel
//   for the guess_entry front end.
//   key_valid/key_code/key_del/key_enter : keyboard event (master -> slave)
//   word_out/letter_count                : packed word and letter count (slave -> master)
//   guess_valid/guess_ready              : accepted-word handshake
interface guess_entry_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_del;
    logic        key_enter;
    logic [24:0] word_out;
    logic [2:0]  letter_count;
    logic        guess_valid;
    logic        guess_ready;

    modport master (
        output key_valid, key_code, key_del, key_enter, guess_ready,
        input  word_out, letter_count, guess_valid
    );

    modport slave (
        input  key_valid, key_code, key_del, key_enter, guess_ready,
        output word_out, letter_count, guess_valid
    );
endinterface

// File: rtl/guess_entry.sv
// guess_entry
//   Collects up to five letter keystrokes into a 25-bit packed word (letter k
//   at [5k+4:5k], empty slots zero), handles backspace, and on enter optionally
//   holds the word for the dictionary lookup window before sampling in_db_i.
//   Accepted words are offered downstream via guess_valid/guess_ready, and the
//   number of accepted guesses per game is counted.
//   Optional feature macro: DB_CHECK_EN (dictionary check). Undefined: enter
//   with five letters goes straight to ACCEPT; checking_o/reject_o tie low.
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   new_game_i   : synchronous clear back to entry, overrides every transition
//   in_db_i      : dictionary hit, sampled when the lookup counter reaches 0
//   bus          : keyboard strobes and downstream word handshake (slave)
//   checking_o   : high while the lookup is in progress
//   reject_o     : one-cycle pulse, word not in dictionary
//   guess_num_o  : accepted guesses this game, saturating at MAX_GUESSES
//   done_o       : high once MAX_GUESSES guesses were accepted
module guess_entry #(
    parameter  int unsigned LOOKUP_CYCLES = 4,
    parameter  int unsigned MAX_GUESSES   = 6,
    localparam int unsigned GW            = $clog2(MAX_GUESSES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_game_i,
    input  logic          in_db_i,
    guess_entry_if.slave  bus,
    output logic          checking_o,
    output logic          reject_o,
    output logic [GW-1:0] guess_num_o,
    output logic          done_o
);

`ifdef DB_CHECK_EN
    localparam int unsigned LW = (LOOKUP_CYCLES > 1) ? $clog2(LOOKUP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_ACCEPT,
        ST_DONE
    } state_t;

    logic [LW-1:0] lk_q, lk_d;
    logic          checking_q, checking_d;
    logic          reject_q, reject_d;
`else
    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_ACCEPT,
        ST_DONE
    } state_t;

    logic unused_in_db;
    assign unused_in_db = in_db_i;
`endif

    state_t        state_q, state_d;
    logic [24:0]   word_q, word_d;
    logic [2:0]    count_q, count_d;
    logic [GW-1:0] num_q, num_d;
    logic          gv_q, gv_d;
    logic          done_q, done_d;
    logic          code_legal;

    assign code_legal = (bus.key_code != 5'd0) && (bus.key_code <= 5'd26);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ENTRY;
            word_q     <= '0;
            count_q    <= '0;
            num_q      <= '0;
            gv_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef DB_CHECK_EN
            lk_q       <= '0;
            checking_q <= 1'b0;
            reject_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            count_q    <= count_d;
            num_q      <= num_d;
            gv_q       <= gv_d;
            done_q     <= done_d;
`ifdef DB_CHECK_EN
            lk_q       <= lk_d;
            checking_q <= checking_d;
            reject_q   <= reject_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        num_d   = num_q;
`ifdef DB_CHECK_EN
        lk_d     = lk_q;
        reject_d = 1'b0;
`endif

        case (state_q)
            ST_ENTRY: begin
                // Priority enter > del > letter when strobed together.
                if (bus.key_valid) begin
                    if (bus.key_enter) begin
                        if (count_q == 3'd5) begin
`ifdef DB_CHECK_EN
                            state_d = ST_CHECK;
                            lk_d    = LW'(LOOKUP_CYCLES - 1);
`else
                            state_d = ST_ACCEPT;
`endif
                        end
                    end else if (bus.key_del) begin
                        if (count_q != 3'd0) begin
                            case (count_q)
                                3'd1:    word_d[4:0]   = '0;
                                3'd2:    word_d[9:5]   = '0;
                                3'd3:    word_d[14:10] = '0;
                                3'd4:    word_d[19:15] = '0;
                                3'd5:    word_d[24:20] = '0;
                                default: ;
                            endcase
                            count_d = count_q - 3'd1;
                        end
                    end else if (code_legal && (count_q < 3'd5)) begin
                        case (count_q)
                            3'd0:    word_d[4:0]   = bus.key_code;
                            3'd1:    word_d[9:5]   = bus.key_code;
                            3'd2:    word_d[14:10] = bus.key_code;
                            3'd3:    word_d[19:15] = bus.key_code;
                            3'd4:    word_d[24:20] = bus.key_code;
                            default: ;
                        endcase
                        count_d = count_q + 3'd1;
                    end
                end
            end
`ifdef DB_CHECK_EN
            ST_CHECK: begin
                if (lk_q == '0) begin
                    if (in_db_i) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        // Letters are kept so the user can edit the rejected word.
                        reject_d = 1'b1;
                        state_d  = ST_ENTRY;
                    end
                end else begin
                    lk_d = lk_q - 1'b1;
                end
            end
`endif
            ST_ACCEPT: begin
                if (bus.guess_ready) begin
                    if (num_q < GW'(MAX_GUESSES)) begin
                        num_d = num_q + 1'b1;
                    end
                    word_d  = '0;
                    count_d = '0;
                    state_d = (num_d == GW'(MAX_GUESSES)) ? ST_DONE : ST_ENTRY;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_ENTRY;
        endcase

        // new_game overrides whatever the state logic above decided.
        if (new_game_i) begin
            state_d = ST_ENTRY;
            word_d  = '0;
            count_d = '0;
            num_d   = '0;
`ifdef DB_CHECK_EN
            lk_d     = '0;
            reject_d = 1'b0;
`endif
        end

        // Status flags are registered from the next state so they align with it.
        gv_d   = (state_d == ST_ACCEPT);
        done_d = (state_d == ST_DONE);
`ifdef DB_CHECK_EN
        checking_d = (state_d == ST_CHECK);
`endif
    end

    assign bus.word_out     = word_q;
    assign bus.letter_count = count_q;
    assign bus.guess_valid  = gv_q;
    assign guess_num_o      = num_q;
    assign done_o           = done_q;
`ifdef DB_CHECK_EN
    assign checking_o = checking_q;
    assign reject_o   = reject_q;
`else
    assign checking_o = 1'b0;
    assign reject_o   = 1'b0;
`endif

endmodule
